// File: rtl/wled_frame_feeder_pkg.sv
// rtl/wled_frame_feeder_pkg.sv - shared types, byte-order constants and colour map for the wled feeder
// Contents:
//   feeder_state_t : scan FSM encoding (ST_IDLE, ST_SCAN)
//   GRB_*_OFS      : bit offsets of each channel byte inside the 24-bit driver word
//   bits_to_grb()  : {R,G,B} on/off bits plus intensity -> {G,R,B} colour word
package wled_frame_feeder_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } feeder_state_t;

  localparam int GRB_G_OFS = 16;
  localparam int GRB_R_OFS = 8;
  localparam int GRB_B_OFS = 0;

  // rgb[2]=R, rgb[1]=G, rgb[0]=B; the driver wants green in the top byte.
  function automatic logic [23:0] bits_to_grb(input logic [2:0] rgb, input logic [7:0] level);
    logic [23:0] w;
    w = '0;
    if (rgb[2]) w[GRB_R_OFS +: 8] = level;
    if (rgb[1]) w[GRB_G_OFS +: 8] = level;
    if (rgb[0]) w[GRB_B_OFS +: 8] = level;
    return w;
  endfunction

endpackage

// File: rtl/wled_frame_feeder_if.sv
// rtl/wled_frame_feeder_if.sv - write bus from the frame feeder into the WS2812 driver colour memory
// Signals:
//   rgb_data [23:0] : colour word {G,R,B}
//   led_num  [7:0]  : LED index being loaded
//   write           : one-cycle load strobe
//   busy            : a scan is in progress
// Modports: master (feeder side, drives everything), slave (driver side).
interface wled_frame_feeder_if;

  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        write;
  logic        busy;

  modport master (output rgb_data, output led_num, output write, output busy);
  modport slave  (input  rgb_data, input  led_num, input  write, input  busy);

endinterface

// File: rtl/wled_refresh_timer.sv
// rtl/wled_refresh_timer.sv - free-running period counter producing a force-rewrite pulse
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   pulse   : high for the one cycle in which the counter sits at REFRESH_CYCLES-1
// REFRESH_CYCLES=0 holds the counter at zero and ties pulse low.
module wled_refresh_timer #(
  parameter int REFRESH_CYCLES = 27000000
) (
  input  logic clk,
  input  logic reset_n,
  output logic pulse
);

  localparam bit          EN   = (REFRESH_CYCLES > 0);
  localparam logic [31:0] LAST = (REFRESH_CYCLES > 0) ? 32'(REFRESH_CYCLES - 1) : 32'd0;

  logic [31:0] cnt;
  logic        hit;

  assign hit   = (cnt == LAST);
  assign pulse = EN && hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (EN) begin
      cnt <= hit ? '0 : cnt + 32'd1;
    end
  end

endmodule

// File: rtl/wled_frame_feeder.sv
// rtl/wled_frame_feeder.sv - converts the packed LED on/off vector into driver colour-memory writes
// Ports:
//   clk       : system clock (shared with the driver)
//   reset_n   : asynchronous active-low reset
//   led_state : 3 bits per LED, {R,G,B} of LED k at [3k+2:3k]
//   drv       : master side of the driver write bus (rgb_data, led_num, write, busy)
// Only LEDs whose value differs from what was last written are sent, except when
// force is set (after reset or a refresh expiry), in which case a scan rewrites all.
module wled_frame_feeder
  import wled_frame_feeder_pkg::*;
#(
  parameter int          NUM_LEDS       = 1,
  parameter logic [7:0]  LEVEL          = 8'h3F,
  parameter int          REFRESH_CYCLES = 27000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3*NUM_LEDS-1:0] led_state,
  wled_frame_feeder_if.master   drv
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_LEDS - 1);

  logic [3*NUM_LEDS-1:0] in_q;
  logic [3*NUM_LEDS-1:0] frame;
  logic [3*NUM_LEDS-1:0] shadow;
  logic [3*NUM_LEDS-1:0] shadow_next;
  feeder_state_t         state;
  logic [7:0]            idx;
  logic                  force_q;     // rewrite every LED in the scan that uses it
  logic                  force_pend;  // expiry seen mid-scan, held for the next scan
  logic                  refresh_pulse;
  logic                  start;
  logic [2:0]            cur_frame;
  logic [2:0]            cur_shadow;

  logic                  write_q;
  logic                  busy_q;
  logic [7:0]            led_num_q;
  logic [23:0]           rgb_q;

  assign drv.write    = write_q;
  assign drv.busy     = busy_q;
  assign drv.led_num  = led_num_q;
  assign drv.rgb_data = rgb_q;

  wled_refresh_timer #(
    .REFRESH_CYCLES (REFRESH_CYCLES)
  ) u_refresh (
    .clk     (clk),
    .reset_n (reset_n),
    .pulse   (refresh_pulse)
  );

  assign start = (in_q != shadow) || force_q;

  always_comb begin
    cur_frame   = '0;
    cur_shadow  = '0;
    shadow_next = shadow;
    for (int k = 0; k < NUM_LEDS; k++) begin
      if (idx == 8'(k)) begin
        cur_frame                = frame[3*k +: 3];
        cur_shadow               = shadow[3*k +: 3];
        shadow_next[3*k +: 3]    = frame[3*k +: 3];
      end
    end
  end

  // Input stage and scan snapshot carry no reset: in_q keeps tracking the host
  // through reset so the post-reset forced scan already carries real colours.
  always_ff @(posedge clk) begin
    in_q <= led_state;
    if (state == ST_IDLE && start) begin
      frame <= in_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      shadow     <= '0;
      force_q    <= 1'b1;
      force_pend <= 1'b0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      led_num_q  <= '0;
      rgb_q      <= '0;
    end else begin
      write_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (refresh_pulse) force_q <= 1'b1;
          if (start) begin
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // An expiry here must not widen the scan already running.
          if (refresh_pulse) force_pend <= 1'b1;
          if ((cur_frame != cur_shadow) || force_q) begin
            write_q   <= 1'b1;
            led_num_q <= idx;
            rgb_q     <= bits_to_grb(cur_frame, LEVEL);
            shadow    <= shadow_next;
          end
          if (idx == LAST_IDX) begin
            state      <= ST_IDLE;
            busy_q     <= 1'b0;
            force_q    <= force_pend || refresh_pulse;
            force_pend <= 1'b0;
          end else begin
            idx <= idx + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wled_frame_feeder.sv
// tb/tb_wled_frame_feeder.sv - directed self-checking bench for wled_frame_feeder
module tb_wled_frame_feeder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rb_n;
  logic [11:0] led_state;
  logic [11:0] led_state_b;

  wled_frame_feeder_if bus_a ();
  wled_frame_feeder_if bus_b ();

  wled_frame_feeder #(.NUM_LEDS(4), .LEVEL(8'h3F), .REFRESH_CYCLES(0)) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .led_state (led_state),
    .drv       (bus_a)
  );

  wled_frame_feeder #(.NUM_LEDS(4), .LEVEL(8'h3F), .REFRESH_CYCLES(100)) dut_b (
    .clk       (clk),
    .reset_n   (rb_n),
    .led_state (led_state_b),
    .drv       (bus_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [7:0]  num;
    logic [23:0] rgb;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  int  cyc = 0;
  int  busy_cnt_a = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_a.write === 1'b1) qa.push_back('{cyc, bus_a.led_num, bus_a.rgb_data});
    if (bus_b.write === 1'b1) qb.push_back('{cyc, bus_b.led_num, bus_b.rgb_data});
    if (bus_a.busy === 1'b1) busy_cnt_a = busy_cnt_a + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input bit use_b, input string tag, input int i, input int ecyc,
                        input logic [7:0] enm, input logic [23:0] ergb);
    wr_t w;
    bit  have;
    have = use_b ? (qb.size() > i) : (qa.size() > i);
    chk({tag, ".present"}, 32'(have), 32'd1);
    if (have) begin
      w = use_b ? qb[i] : qa[i];
      chk({tag, ".cyc"}, 32'(w.cyc), 32'(ecyc));
      chk({tag, ".led_num"}, 32'(w.num), 32'(enm));
      chk({tag, ".rgb"}, 32'(w.rgb), 32'(ergb));
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [23:0] rgb_b_exp [4];
  int r;
  int c;

  initial begin
    rgb_b_exp   = '{24'h00003F, 24'h3F003F, 24'h3F3F00, 24'h003F3F};
    reset_n     = 1'b0;
    rb_n        = 1'b0;
    led_state   = '0;
    led_state_b = {3'b101, 3'b110, 3'b011, 3'b001};
    step(3);

    chk("rst.write", 32'(bus_a.write), 32'd0);
    chk("rst.busy", 32'(bus_a.busy), 32'd0);
    chk("rst.led_num", 32'(bus_a.led_num), 32'd0);
    chk("rst.rgb", 32'(bus_a.rgb_data), 32'd0);

    // Forced full scan after reset, all-off colours.
    qa.delete();
    qb.delete();
    busy_cnt_a = 0;
    r = cyc;
    reset_n = 1'b1;
    rb_n    = 1'b1;
    step(8);
    chk("init.count", 32'(qa.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk_wr(1'b0, "init", k, r + 2 + k, 8'(k), 24'h000000);
    chk("init.busy_cycles", 32'(busy_cnt_a), 32'd4);

    // No periodic refresh on dut_a; dut_b rewrites every 100 cycles.
    qa.delete();
    step(300);
    chk("norefresh.count", 32'(qa.size()), 32'd0);
    chk("refresh.count", 32'(qb.size()), 32'd16);
    for (int m = 0; m < 4; m++)
      for (int k = 0; k < 4; k++)
        chk_wr(1'b1, "refresh", 4*m + k, r + 2 + 100*m + k, 8'(k), rgb_b_exp[k]);

    // Single dirty LED.
    qa.delete();
    c = cyc;
    led_state[8:6] = 3'b100;
    step(10);
    chk("one.count", 32'(qa.size()), 32'd1);
    chk_wr(1'b0, "one", 0, c + 5, 8'd2, 24'h003F00);

    // Two dirty LEDs with two clean ones between.
    qa.delete();
    c = cyc;
    led_state[2:0]  = 3'b011;
    led_state[11:9] = 3'b111;
    step(10);
    chk("two.count", 32'(qa.size()), 32'd2);
    chk_wr(1'b0, "two0", 0, c + 3, 8'd0, 24'h3F003F);
    chk_wr(1'b0, "two1", 1, c + 6, 8'd3, 24'h3F3F3F);

    // Full scan, LED1 changed again once the scan has passed it.
    qa.delete();
    c = cyc;
    led_state = {3'b101, 3'b110, 3'b010, 3'b001};
    step(4);
    led_state[5:3] = 3'b111;
    step(2);
    chk("frozen.busy_low", 32'(bus_a.busy), 32'd0);
    step(1);
    chk("frozen.busy_again", 32'(bus_a.busy), 32'd1);
    step(6);
    chk("frozen.count", 32'(qa.size()), 32'd5);
    chk_wr(1'b0, "frozen0", 0, c + 3, 8'd0, 24'h00003F);
    chk_wr(1'b0, "frozen1", 1, c + 4, 8'd1, 24'h3F0000);
    chk_wr(1'b0, "frozen2", 2, c + 5, 8'd2, 24'h3F3F00);
    chk_wr(1'b0, "frozen3", 3, c + 6, 8'd3, 24'h003F3F);
    chk_wr(1'b0, "rescan1", 4, c + 9, 8'd1, 24'h3F3F3F);

    // Reset while idx=2: outputs clear asynchronously, then full rewrite.
    qa.delete();
    c = cyc;
    led_state = {3'b000, 3'b011, 3'b100, 3'b010};
    step(4);
    chk("midrst.pre_write", 32'(bus_a.write), 32'd1);
    chk("midrst.pre_led_num", 32'(bus_a.led_num), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst.write", 32'(bus_a.write), 32'd0);
    chk("midrst.busy", 32'(bus_a.busy), 32'd0);
    chk("midrst.led_num", 32'(bus_a.led_num), 32'd0);
    chk("midrst.rgb", 32'(bus_a.rgb_data), 32'd0);
    step(3);
    qa.delete();
    r = cyc;
    reset_n = 1'b1;
    step(8);
    chk("postrst.count", 32'(qa.size()), 32'd4);
    chk_wr(1'b0, "postrst0", 0, r + 2, 8'd0, 24'h3F0000);
    chk_wr(1'b0, "postrst1", 1, r + 3, 8'd1, 24'h003F00);
    chk_wr(1'b0, "postrst2", 2, r + 4, 8'd2, 24'h3F003F);
    chk_wr(1'b0, "postrst3", 3, r + 5, 8'd3, 24'h000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wled_frame_feeder.md
Name: wled_frame_feeder

Overview:
- Upstream feeder for the WS2812 serial driver in the wled plugin.
- Takes the host-side packed LED on/off vector (3 bits per LED: R, G, B) and converts it to 24-bit GRB colour words.
- Issues single-cycle write strobes (rgb_data / led_num / write) that load the driver's per-LED colour memory.
- Writes only LEDs that changed, plus a periodic forced full rewrite for glitch recovery.

Parameters:
- NUM_LEDS, 1, LEDs on the chain; legal range 1..256.
- LEVEL, 8'h3F, channel intensity driven when a colour bit is on.
- REFRESH_CYCLES, 27000000, clk cycles between forced full rewrites; 0 disables periodic refresh.

Ports:
- clk  input  1  system clock, same clock as the driver.
- reset_n  input  1  asynchronous active-low reset.
- led_state  input  3*NUM_LEDS  host vector; bits [3k+2:3k] = {R,G,B} of LED k; synchronous to clk.
- rgb_data  output  24  colour word to driver, order {G[7:0],R[7:0],B[7:0]}.
- led_num  output  8  LED index to driver.
- write  output  1  one-cycle write strobe to driver.
- busy  output  1  high while a scan is in progress.

Behaviour:
- Reset (async assert, sync release): write=0, led_num=0, rgb_data=0, busy=0, state=IDLE, idx=0, shadow=0, refresh counter=0, force=1. The first scan after reset therefore rewrites every LED.
- Registers: in_q (registered led_state), frame (scan snapshot), shadow (last value written per LED), idx[7:0], refresh counter, force flag.
- in_q <= led_state every cycle.
- IDLE:
  - Condition: (in_q != shadow) or force.
  - When true: frame <= in_q, idx <= 0, busy <= 1, next state SCAN.
  - Otherwise stay in IDLE with write=0.
- SCAN, one LED per cycle:
  - If frame[idx] != shadow[idx] or force: write <= 1, led_num <= idx, rgb_data <= map(frame[idx]), shadow[idx] <= frame[idx].
  - Otherwise write <= 0.
  - If idx == NUM_LEDS-1: state <= IDLE, busy <= 0, force <= 0 (unless re-armed this cycle). Otherwise idx <= idx+1.
- Colour map:
  - G byte = G ? LEVEL : 0; R byte = R ? LEVEL : 0; B byte = B ? LEVEL : 0.
  - rgb_data = {G byte, R byte, B byte}.
- Latency: a led_state change sampled at edge N causes the write for LED k no earlier than the cycle after edge N+2+k; write high for exactly one cycle per LED written.
- Consistency: frame is frozen for the whole scan. led_state changes during SCAN are ignored until the next IDLE compare, which occurs the cycle after the scan ends. No torn frames.
- Refresh:
  - The counter increments every cycle when REFRESH_CYCLES>0.
  - On reaching REFRESH_CYCLES-1 it wraps to 0 and sets force.
  - Expiry during SCAN sets force for the next scan; it does not alter the current one.
  - The end-of-scan clear loses to a same-cycle expiry set.
- Simultaneous dirty + force: one scan that writes all LEDs.
- NUM_LEDS=1: SCAN lasts one cycle; idx is always 0.
- NUM_LEDS=256: idx wraps 255→0 only via the IDLE reload.
- Reset mid-scan: all state returns to reset values; a partially written frame is fully rewritten on the next scan (force=1).
- No back-pressure: the driver accepts a write every cycle.

Decomposition:
- Shared wled package holds:
  - state encoding (ST_IDLE, ST_SCAN);
  - channel byte-order constants (GRB offsets 16/8/0);
  - function bits_to_grb(3-bit, LEVEL) returning 24 bits.
- One natural sub-module: wled_refresh_timer (counter plus force pulse; REFRESH_CYCLES=0 ties the pulse low).
- Everything else lives in wled_frame_feeder.

Test Plan:
- NUM_LEDS=4, LEVEL=8'h3F, led_state=0, release reset -> 4 consecutive write pulses, led_num 0,1,2,3, rgb_data=24'h000000 each; busy high 4 cycles then low.
- After idle, set LED2 to {R=1,G=0,B=0} -> exactly one write, led_num=2, rgb_data=24'h003F00; no other writes.
- Set LED0 to {G=1,B=1} and LED3 to {R=1,G=1,B=1} in the same cycle -> writes led_num=0 rgb_data=24'h3F003F, then led_num=3 rgb_data=24'h3F3F3F, separated by the two skipped LEDs (write low two cycles).
- During a full scan, toggle LED1 after idx has passed 1 -> current scan unchanged; one following write led_num=1 carrying the new value starting the cycle after busy falls.
- REFRESH_CYCLES=100, static input -> full 4-LED rewrite every 100 cycles with unchanged rgb_data; REFRESH_CYCLES=0 -> no writes after the initial reset scan.
- Assert reset_n low while idx=2 -> write, busy, led_num, rgb_data go 0 immediately (asynchronously); after release a full 4-LED rewrite occurs.
